// File: rtl/max_reduce_pkg.sv
// Shared types and width helpers for the max_reduce_seq controller and its comparator.
package max_reduce_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    ACC  = 2'd1,
    DONE = 2'd2
  } state_t;

  localparam int MAX_LEN_DEFAULT = 8;

  // A one-beat burst still needs a 1-bit index port.
  function automatic int idx_width(input int max_len);
    return (max_len > 1) ? $clog2(max_len) : 1;
  endfunction

  function automatic int cnt_width(input int max_len);
    return $clog2(max_len + 1);
  endfunction

  localparam int IW = idx_width(MAX_LEN_DEFAULT);
  localparam int CW = cnt_width(MAX_LEN_DEFAULT);

endpackage

// File: rtl/max_reduce_seq_max2_cmp.sv
// Combinational 2-input unsigned greater-than used by max_reduce_seq.
// Define MAX_REDUCE_APPROX_EN to ignore the APPROX_BITS low-order bits of both operands.
module max2_cmp #(
  parameter int W           = 4,
  parameter int APPROX_BITS = 1
) (
  input  logic [W-1:0] a,
  input  logic [W-1:0] b,
  output logic         a_gt_b
);

  if (APPROX_BITS < 1 || APPROX_BITS >= W) begin : g_bad_approx
    $error("max2_cmp: APPROX_BITS must satisfy 0 < APPROX_BITS < W");
  end

`ifdef MAX_REDUCE_APPROX_EN
  // Low-bit differences compare as equal, so the controller keeps the earlier beat.
  localparam int LSB = APPROX_BITS;
`else
  localparam int LSB = 0;
`endif

  assign a_gt_b = (a[W-1:LSB] > b[W-1:LSB]);

endmodule

// File: rtl/max_reduce_seq.sv
// Burst max reduction over a valid/ready stream using a single shared comparator.
// Optional MAX_REDUCE_APPROX_EN selects the coarse comparator inside max2_cmp.
//
// state | meaning
// IDLE  | waiting for the first beat of a burst
// ACC   | folding further beats into the running max/argmax
// DONE  | result presented on out_*, held until out_ready
module max_reduce_seq
  import max_reduce_pkg::*;
#(
  parameter int W           = 4,
  parameter int MAX_LEN     = 8,
  parameter int APPROX_BITS = 1
) (
  input  logic                           clk,
  input  logic                           rst_n,
  input  logic                           in_valid,
  output logic                           in_ready,
  input  logic [W-1:0]                   in_data,
  input  logic                           in_last,
  output logic                           out_valid,
  input  logic                           out_ready,
  output logic [W-1:0]                   out_max,
  output logic [idx_width(MAX_LEN)-1:0]  out_idx,
  output logic [cnt_width(MAX_LEN)-1:0]  out_cnt,
  output logic                           out_trunc
);

  localparam int IDX_W = idx_width(MAX_LEN);
  localparam int CNT_W = cnt_width(MAX_LEN);
  localparam logic [CNT_W-1:0] LEN_CAP = CNT_W'(MAX_LEN);

  state_t             state;
  logic [W-1:0]       acc;
  logic [IDX_W-1:0]   idx;
  logic [CNT_W-1:0]   cnt;
  logic               trunc;

  logic               beat;
  logic               data_gt;
  logic [CNT_W-1:0]   cnt_nxt;
  logic               at_cap;

  max2_cmp #(
    .W           (W),
    .APPROX_BITS (APPROX_BITS)
  ) u_cmp (
    .a      (in_data),
    .b      (acc),
    .a_gt_b (data_gt)
  );

  assign beat    = in_valid & in_ready;
  assign cnt_nxt = cnt + CNT_W'(1);
  assign at_cap  = (cnt_nxt == LEN_CAP);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      acc       <= '0;
      idx       <= '0;
      cnt       <= '0;
      trunc     <= 1'b0;
      in_ready  <= 1'b0;
      out_valid <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          in_ready <= 1'b1;
          if (beat) begin
            acc <= in_data;
            idx <= '0;
            cnt <= CNT_W'(1);
            if (in_last || (MAX_LEN == 1)) begin
              state     <= DONE;
              in_ready  <= 1'b0;
              out_valid <= 1'b1;
              trunc     <= ~in_last;
            end else begin
              state <= ACC;
              trunc <= 1'b0;
            end
          end
        end

        ACC: begin
          if (beat) begin
            // Strict compare: a tie leaves the earlier index in place.
            if (data_gt) begin
              acc <= in_data;
              idx <= IDX_W'(cnt);
            end
            cnt <= cnt_nxt;
            if (in_last || at_cap) begin
              state     <= DONE;
              in_ready  <= 1'b0;
              out_valid <= 1'b1;
              trunc     <= ~in_last;
            end
          end
        end

        DONE: begin
          if (out_ready) begin
            state     <= IDLE;
            out_valid <= 1'b0;
            in_ready  <= 1'b1;
          end
        end

        default: begin
          state     <= IDLE;
          in_ready  <= 1'b0;
          out_valid <= 1'b0;
        end
      endcase
    end
  end

  assign out_max   = acc;
  assign out_idx   = idx;
  assign out_cnt   = cnt;
  assign out_trunc = trunc;

endmodule
